// File: rtl/hbus_arb_pkg.sv
// Shared types and constants for the HyperBus two-port arbiter.
package hbus_arb_pkg;

    typedef enum logic [7:0] {
        INIT_WAIT = 8'b0000_0001,
        INIT_WR   = 8'b0000_0010,
        INIT_REL  = 8'b0000_0100,
        IDLE      = 8'b0000_1000,
        ISSUE     = 8'b0001_0000,
        XFER      = 8'b0010_0000,
        RELEASE   = 8'b0100_0000,
        ERROR     = 8'b1000_0000
    } state_t;

    localparam logic [31:0] CR0_ADR_DEF   = 32'h0000_0800;
    localparam logic [15:0] CR0_VALUE_DEF = 16'h8F1F;

    localparam logic PORT_M0 = 1'b0;
    localparam logic PORT_M1 = 1'b1;

endpackage

// File: rtl/hbus_rr_pick.sv
// Two-way round-robin picker; with both requesting, the port that
// did not win last time gets the grant.
module hbus_rr_pick
    import hbus_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    output logic [1:0] grant
);

    always_comb begin
        grant = 2'b00;
        if (&req)
            grant = (last_gnt == PORT_M1) ? 2'b01 : 2'b10;
        else
            grant = req;
    end

endmodule

// File: rtl/hbus_arbiter.sv
// Shares one HyperBus controller between a CPU port (m0) and a DMA
// port (m1); writes CR0 once after reset, then grants bursts.
module hbus_arbiter
    import hbus_arb_pkg::*;
#(
    parameter int                  WIDTH       = 8,
    parameter int                  ADDR_LENGTH = 32,
    parameter int                  LEN_W       = 8,
    parameter bit                  INIT_EN     = 1'b1,
    parameter logic [ADDR_LENGTH-1:0] CR0_ADR  = ADDR_LENGTH'(CR0_ADR_DEF),
    parameter logic [2*WIDTH-1:0]  CR0_VALUE   = (2*WIDTH)'(CR0_VALUE_DEF)
) (
    input  logic                   clk90,
    input  logic                   rst,
    input  logic                   m0_req,
    input  logic                   m0_we,
    input  logic [ADDR_LENGTH-1:0] m0_adr,
    input  logic [LEN_W-1:0]       m0_len,
    input  logic [2*WIDTH-1:0]     m0_wdat,
    output logic                   m0_gnt,
    output logic                   m0_wack,
    output logic [2*WIDTH-1:0]     m0_rdat,
    output logic                   m0_rvalid,
    output logic                   m0_done,
    input  logic                   m1_req,
    input  logic                   m1_we,
    input  logic [ADDR_LENGTH-1:0] m1_adr,
    input  logic [LEN_W-1:0]       m1_len,
    input  logic [2*WIDTH-1:0]     m1_wdat,
    output logic                   m1_gnt,
    output logic                   m1_wack,
    output logic [2*WIDTH-1:0]     m1_rdat,
    output logic                   m1_rvalid,
    output logic                   m1_done,
    output logic [ADDR_LENGTH-1:0] hb_adr_o,
    output logic [2*WIDTH-1:0]     hb_dat_o,
    input  logic [2*WIDTH-1:0]     hb_dat_i,
    input  logic                   hb_ready_i,
    input  logic                   hb_valid_i,
    input  logic                   hb_busy_i,
    input  logic                   hb_error_i,
    output logic                   hb_wrq_o,
    output logic                   hb_rrq_o,
    output logic                   hb_reg_space_o,
    output logic                   init_done,
    output logic                   err_o
);

    state_t                 state;
    state_t                 state_n;
    logic                   own;
    logic                   gnt_r;
    logic                   we_r;
    logic [ADDR_LENGTH-1:0] adr_r;
    logic [LEN_W-1:0]       len_r;
    logic [LEN_W:0]         cnt;
    logic [2*WIDTH-1:0]     rdat_r;
    logic                   rvalid_r;
    logic [1:0]             done_r;
    logic                   last_gnt;
    logic                   init_done_r;

    logic [1:0]             req_m;
    logic [1:0]             pick;
    logic                   win;
    logic                   strobe;
    logic                   last_word;
    logic                   in_burst;
    logic                   xfer_wr;

    // A port whose done is pulsing this cycle is not yet re-requesting.
    assign req_m = {m1_req & ~done_r[1], m0_req & ~done_r[0]};

    hbus_rr_pick u_pick (
        .req      (req_m),
        .last_gnt (last_gnt),
        .grant    (pick)
    );

    assign win       = pick[1];
    assign strobe    = we_r ? hb_ready_i : hb_valid_i;
    assign last_word = (cnt == {1'b0, len_r});

    always_ff @(posedge clk90 or posedge rst) begin
        if (rst)
            state <= INIT_EN ? INIT_WAIT : IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        if (hb_error_i) begin
            state_n = ERROR;
        end else begin
            unique case (state)
                INIT_WAIT: if (!hb_busy_i) state_n = INIT_WR;
                INIT_WR:   if (hb_ready_i) state_n = INIT_REL;
                INIT_REL:  if (!hb_busy_i) state_n = IDLE;
                IDLE:      if ((|req_m) && !hb_busy_i) state_n = ISSUE;
                ISSUE:     state_n = XFER;
                XFER:      if (strobe && last_word) state_n = RELEASE;
                RELEASE:   if (!hb_busy_i) state_n = IDLE;
                ERROR:     state_n = ERROR;
                default:   state_n = ERROR;
            endcase
        end
    end

    always_ff @(posedge clk90 or posedge rst) begin
        if (rst) begin
            own         <= PORT_M0;
            gnt_r       <= 1'b0;
            we_r        <= 1'b0;
            adr_r       <= '0;
            len_r       <= '0;
            cnt         <= '0;
            rdat_r      <= '0;
            rvalid_r    <= 1'b0;
            done_r      <= 2'b00;
            last_gnt    <= PORT_M1;
            init_done_r <= 1'b0;
        end else begin
            done_r   <= 2'b00;
            rvalid_r <= 1'b0;
            if (!INIT_EN || (state == INIT_REL && state_n == IDLE))
                init_done_r <= 1'b1;
            if (state == IDLE && state_n == ISSUE) begin
                own   <= win;
                gnt_r <= 1'b1;
                we_r  <= win ? m1_we  : m0_we;
                adr_r <= win ? m1_adr : m0_adr;
                len_r <= win ? m1_len : m0_len;
            end
            if (state == ISSUE)
                cnt <= '0;
            if (state == XFER && strobe)
                cnt <= cnt + 1'b1;
            if (state == XFER && !we_r && hb_valid_i) begin
                rdat_r   <= hb_dat_i;
                rvalid_r <= 1'b1;
            end
            if (state == RELEASE && state_n == IDLE) begin
                done_r   <= own ? 2'b10 : 2'b01;
                gnt_r    <= 1'b0;
                last_gnt <= own;
            end
            if (state_n == ERROR)
                gnt_r <= 1'b0;
        end
    end

    assign in_burst = (state == ISSUE) || (state == XFER);
    assign xfer_wr  = (state == XFER) && we_r;

    assign hb_wrq_o       = (state == INIT_WR) || (in_burst && we_r);
    assign hb_rrq_o       = in_burst && !we_r;
    assign hb_reg_space_o = (state == INIT_WR);
    assign hb_adr_o       = (state == INIT_WR) ? CR0_ADR : adr_r;

    always_comb begin
        hb_dat_o = '0;
        if (state == INIT_WR)
            hb_dat_o = CR0_VALUE;
        else if (in_burst && we_r)
            hb_dat_o = own ? m1_wdat : m0_wdat;
    end

    assign m0_gnt    = gnt_r & ~own;
    assign m1_gnt    = gnt_r &  own;
    assign m0_wack   = xfer_wr & hb_ready_i & m0_gnt;
    assign m1_wack   = xfer_wr & hb_ready_i & m1_gnt;
    assign m0_rvalid = rvalid_r & m0_gnt;
    assign m1_rvalid = rvalid_r & m1_gnt;
    assign m0_rdat   = own ? '0 : rdat_r;
    assign m1_rdat   = own ? rdat_r : '0;
    assign m0_done   = done_r[0];
    assign m1_done   = done_r[1];
    assign init_done = init_done_r;
    assign err_o     = (state == ERROR);

endmodule

// File: tb/tb_hbus_arbiter.sv
// Directed bench for hbus_arbiter; the controller side is driven by hand.
module tb_hbus_arbiter;

    logic        clk90 = 1'b0;
    logic        rst;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_adr, m1_adr;
    logic [7:0]  m0_len, m1_len;
    logic [15:0] m0_wdat, m1_wdat;
    logic        m0_gnt, m0_wack, m0_rvalid, m0_done;
    logic        m1_gnt, m1_wack, m1_rvalid, m1_done;
    logic [15:0] m0_rdat, m1_rdat;
    logic [31:0] hb_adr_o;
    logic [15:0] hb_dat_o, hb_dat_i;
    logic        hb_ready_i, hb_valid_i, hb_busy_i, hb_error_i;
    logic        hb_wrq_o, hb_rrq_o, hb_reg_space_o;
    logic        init_done, err_o;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk90 = ~clk90;

    hbus_arbiter dut (
        .clk90          (clk90),
        .rst            (rst),
        .m0_req         (m0_req),
        .m0_we          (m0_we),
        .m0_adr         (m0_adr),
        .m0_len         (m0_len),
        .m0_wdat        (m0_wdat),
        .m0_gnt         (m0_gnt),
        .m0_wack        (m0_wack),
        .m0_rdat        (m0_rdat),
        .m0_rvalid      (m0_rvalid),
        .m0_done        (m0_done),
        .m1_req         (m1_req),
        .m1_we          (m1_we),
        .m1_adr         (m1_adr),
        .m1_len         (m1_len),
        .m1_wdat        (m1_wdat),
        .m1_gnt         (m1_gnt),
        .m1_wack        (m1_wack),
        .m1_rdat        (m1_rdat),
        .m1_rvalid      (m1_rvalid),
        .m1_done        (m1_done),
        .hb_adr_o       (hb_adr_o),
        .hb_dat_o       (hb_dat_o),
        .hb_dat_i       (hb_dat_i),
        .hb_ready_i     (hb_ready_i),
        .hb_valid_i     (hb_valid_i),
        .hb_busy_i      (hb_busy_i),
        .hb_error_i     (hb_error_i),
        .hb_wrq_o       (hb_wrq_o),
        .hb_rrq_o       (hb_rrq_o),
        .hb_reg_space_o (hb_reg_space_o),
        .init_done      (init_done),
        .err_o          (err_o)
    );

    task automatic cyc();
        @(posedge clk90);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic serve(input bit p);
        cyc();
        chk("rr_gnt_m0", m0_gnt, !p);
        chk("rr_gnt_m1", m1_gnt, p);
        cyc();
        hb_ready_i = 1'b1;
        hb_busy_i  = 1'b1;
        cyc();
        hb_ready_i = 1'b0;
        hb_busy_i  = 1'b0;
        chk("rr_wrq_drop", hb_wrq_o, 1'b0);
        cyc();
        chk("rr_done_m0", m0_done, !p);
        chk("rr_done_m1", m1_done, p);
    endtask

    logic [15:0] words [4];

    initial begin
        words[0] = 16'h1111; words[1] = 16'h2222;
        words[2] = 16'h3333; words[3] = 16'h4444;
        rst = 1'b1;
        m0_req = 0; m0_we = 0; m0_adr = 0; m0_len = 0; m0_wdat = 0;
        m1_req = 0; m1_we = 0; m1_adr = 0; m1_len = 0; m1_wdat = 0;
        hb_dat_i = 0; hb_ready_i = 0; hb_valid_i = 0;
        hb_busy_i = 0; hb_error_i = 0;
        cyc();
        chk("rst_wrq", hb_wrq_o, 1'b0);
        chk("rst_rrq", hb_rrq_o, 1'b0);
        chk("rst_regsp", hb_reg_space_o, 1'b0);
        chk("rst_adr", hb_adr_o, 32'h0);
        chk("rst_dat", hb_dat_o, 16'h0);
        chk("rst_init_done", init_done, 1'b0);
        chk("rst_err", err_o, 1'b0);
        chk("rst_gnt", {m1_gnt, m0_gnt}, 2'b00);

        // CR0 init with a pending m0 write that must wait
        m0_req = 1; m0_we = 1; m0_adr = 32'h100; m0_len = 8'd3;
        m0_wdat = words[0];
        rst = 1'b0;
        cyc();
        chk("init_wrq", hb_wrq_o, 1'b1);
        chk("init_regsp", hb_reg_space_o, 1'b1);
        chk("init_adr", hb_adr_o, 32'h800);
        chk("init_dat", hb_dat_o, 16'h8F1F);
        chk("init_no_gnt", m0_gnt, 1'b0);
        cyc();
        chk("init_wrq_hold", hb_wrq_o, 1'b1);
        hb_ready_i = 1; hb_busy_i = 1;
        cyc();
        hb_ready_i = 0;
        chk("init_wrq_drop", hb_wrq_o, 1'b0);
        chk("init_busy_wait", init_done, 1'b0);
        cyc();
        chk("init_rel_gnt", m0_gnt, 1'b0);
        hb_busy_i = 0;
        cyc();
        chk("init_done", init_done, 1'b1);
        chk("idle_no_gnt", m0_gnt, 1'b0);

        // m0 write burst, 4 words
        cyc();
        chk("wr_gnt", m0_gnt, 1'b1);
        chk("wr_wrq_issue", hb_wrq_o, 1'b1);
        chk("wr_regsp", hb_reg_space_o, 1'b0);
        chk("wr_adr", hb_adr_o, 32'h100);
        cyc();
        m0_adr = 32'hDEAD_0000; m0_len = 8'd0;
        for (int i = 0; i < 4; i++) begin
            m0_wdat = words[i];
            hb_ready_i = 1; hb_busy_i = 1;
            #1;
            chk("wr_wack", m0_wack, 1'b1);
            chk("wr_m1_wack", m1_wack, 1'b0);
            chk("wr_dat", hb_dat_o, words[i]);
            chk("wr_wrq", hb_wrq_o, 1'b1);
            chk("wr_adr_stable", hb_adr_o, 32'h100);
            cyc();
        end
        hb_ready_i = 0;
        chk("wr_wrq_low", hb_wrq_o, 1'b0);
        chk("wr_no_done_busy", m0_done, 1'b0);
        cyc();
        chk("wr_no_done_busy2", m0_done, 1'b0);
        chk("wr_gnt_held", m0_gnt, 1'b1);
        hb_busy_i = 0;
        cyc();
        chk("wr_done", m0_done, 1'b1);
        chk("wr_gnt_clr", m0_gnt, 1'b0);
        cyc();
        m0_req = 0;
        chk("wr_done_once", m0_done, 1'b0);
        chk("wr_no_regrant", m0_gnt, 1'b0);

        // m1 read burst, 2 words
        m1_req = 1; m1_we = 0; m1_adr = 32'h200; m1_len = 8'd1;
        cyc();
        chk("rd_gnt", m1_gnt, 1'b1);
        chk("rd_rrq", hb_rrq_o, 1'b1);
        chk("rd_wrq", hb_wrq_o, 1'b0);
        cyc();
        hb_valid_i = 1; hb_dat_i = 16'hA5A5; hb_busy_i = 1;
        cyc();
        chk("rd_rvalid0", m1_rvalid, 1'b1);
        chk("rd_rdat0", m1_rdat, 16'hA5A5);
        chk("rd_rrq_mid", hb_rrq_o, 1'b1);
        hb_dat_i = 16'h5A5A;
        cyc();
        hb_valid_i = 0; m1_req = 0;
        chk("rd_rvalid1", m1_rvalid, 1'b1);
        chk("rd_rdat1", m1_rdat, 16'h5A5A);
        chk("rd_rrq_drop", hb_rrq_o, 1'b0);
        chk("rd_m0_rvalid", m0_rvalid, 1'b0);
        cyc();
        chk("rd_rvalid_end", m1_rvalid, 1'b0);
        hb_busy_i = 0;
        cyc();
        chk("rd_done", m1_done, 1'b1);

        // both requesting, round robin
        m0_req = 1; m0_we = 1; m0_len = 0;
        m1_req = 1; m1_we = 1; m1_len = 0;
        serve(1'b0);
        serve(1'b1);
        serve(1'b0);
        m0_req = 0; m1_req = 0;
        cyc();

        // error mid m0 write
        m0_req = 1; m0_we = 1; m0_adr = 32'h300; m0_len = 8'd3;
        cyc();
        cyc();
        hb_ready_i = 1; hb_busy_i = 1;
        cyc();
        cyc();
        hb_ready_i = 0; hb_error_i = 1;
        cyc();
        hb_error_i = 0; hb_busy_i = 0;
        chk("err_o", err_o, 1'b1);
        chk("err_wrq", hb_wrq_o, 1'b0);
        chk("err_gnt", m0_gnt, 1'b0);
        chk("err_no_done", m0_done, 1'b0);
        cyc();
        cyc();
        chk("err_sticky", err_o, 1'b1);
        chk("err_no_done2", m0_done, 1'b0);
        rst = 1; m0_req = 0;
        #1;
        chk("err_rst_clr", err_o, 1'b0);
        chk("err_rst_init", init_done, 1'b0);
        cyc();
        rst = 0;
        cyc();
        chk("err_reinit_wrq", hb_wrq_o, 1'b1);
        chk("err_reinit_regsp", hb_reg_space_o, 1'b1);
        hb_ready_i = 1;
        cyc();
        hb_ready_i = 0;
        cyc();
        chk("err_reinit_done", init_done, 1'b1);

        // reset mid m1 read
        m1_req = 1; m1_we = 0; m1_adr = 32'h400; m1_len = 8'd3;
        cyc();
        cyc();
        hb_valid_i = 1; hb_dat_i = 16'h1234; hb_busy_i = 1;
        cyc();
        chk("rrst_rrq_pre", hb_rrq_o, 1'b1);
        chk("rrst_rvalid_pre", m1_rvalid, 1'b1);
        rst = 1;
        #1;
        chk("rrst_rrq", hb_rrq_o, 1'b0);
        chk("rrst_gnt", m1_gnt, 1'b0);
        chk("rrst_rvalid", m1_rvalid, 1'b0);
        hb_valid_i = 0; m1_req = 0; hb_busy_i = 0;
        cyc();
        rst = 0;
        cyc();
        chk("rrst_init_wrq", hb_wrq_o, 1'b1);
        chk("rrst_init_adr", hb_adr_o, 32'h800);
        hb_ready_i = 1;
        cyc();
        hb_ready_i = 0;
        chk("rrst_no_done", m1_done, 1'b0);
        cyc();
        chk("rrst_init_done", init_done, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/hbus_arbiter.md
Name: hbus_arbiter

Overview:
Two-requester front end that shares the single HyperBus primary controller between a CPU port (m0) and a DMA port (m1). After reset it writes Configuration Register 0 once. It then grants bursts round-robin and drives the controller's hold-high wrq/rrq request protocol. It counts words on the controller's ready and valid strobes, and it releases the bus only once the controller reports not busy.

Parameters:
WIDTH, 8, HyperBus DQ width; data words are 2*WIDTH bits
ADDR_LENGTH, 32, address width
LEN_W, 8, burst length field width; a burst is len+1 words (1..256)
INIT_EN, 1, issue the CR0 write after reset
CR0_ADR, 32'h0000_0800, register-space address of CR0
CR0_VALUE, 16'h8F1F, value written to CR0

Ports:
clk90  in  1  clock; same frequency as the controller clock
rst  in  1  reset; asynchronous, active-high
m0_req / m1_req  in  1  request; hold high until mN_done
m0_we / m1_we  in  1  1=write burst, 0=read burst
m0_adr / m1_adr  in  ADDR_LENGTH  burst start address
m0_len / m1_len  in  LEN_W  number of words minus 1
m0_wdat / m1_wdat  in  2*WIDTH  current write word
m0_gnt / m1_gnt  out  1  port owns the bus
m0_wack / m1_wack  out  1  current write word consumed; present the next word on the following cycle
m0_rdat / m1_rdat  out  2*WIDTH  read word
m0_rvalid / m1_rvalid  out  1  read word valid, one-cycle pulse
m0_done / m1_done  out  1  burst complete, one-cycle pulse
hb_adr_o  out  ADDR_LENGTH  to controller adr_i
hb_dat_o  out  2*WIDTH  to controller dat_i
hb_dat_i  in  2*WIDTH  from controller dat_o
hb_ready_i / hb_valid_i / hb_busy_i / hb_error_i  in  1  controller status
hb_wrq_o / hb_rrq_o / hb_reg_space_o  out  1  controller requests
init_done  out  1  CR0 write finished
err_o  out  1  sticky error

Behaviour:
- Reset values: every output 0. State is INIT_WAIT if INIT_EN=1, otherwise IDLE. last_gnt resets to 1, so m0 wins first.
- Reset mid-operation: wrq/rrq drop immediately and the burst is abandoned without a done pulse.
- INIT_WAIT: wait for hb_busy_i=0, then go to INIT_WR.
- INIT_WR: drive hb_wrq_o=1, hb_reg_space_o=1, hb_adr_o=CR0_ADR, hb_dat_o=CR0_VALUE. On the first cycle with hb_ready_i=1, drop wrq and go to INIT_REL.
- INIT_REL: on hb_busy_i=0, set init_done=1 and go to IDLE. With INIT_EN=0, init_done is 1 from the first clock after reset.
- IDLE: when some req=1 and hb_busy_i=0, pick a port.
  - Only one requesting: that port wins.
  - Both requesting: the port != last_gnt wins.
  - Latch we, adr and len into internal registers; set gnt; go to ISSUE.
- ISSUE (one cycle): assert hb_wrq_o or hb_rrq_o per the latched we, with hb_reg_space_o=0. Word counter = 0. Go to XFER.
- XFER write:
  - hb_dat_o is the granted port's wdat.
  - wack = hb_ready_i & gnt, combinational.
  - Each ready cycle increments the counter.
  - On the ready cycle where counter==len, hb_wrq_o is 0 from the next cycle; go to RELEASE.
- XFER read:
  - Each hb_valid_i cycle: rdat <= hb_dat_i and rvalid pulses one cycle later, registered.
  - Counter increments per valid.
  - On the valid where counter==len, drop hb_rrq_o; go to RELEASE.
- RELEASE: wait for hb_busy_i=0.
  - Then pulse the winner's done, clear gnt, set last_gnt to the winner, go to IDLE.
  - The earliest next grant is the cycle after done.
- Requests and grant:
  - A requester dropping req mid-burst is ignored; the burst runs to len+1 words.
  - A req still high in the cycle after done is treated as a new request.
  - Latched adr/len/we stay stable for the whole burst regardless of the input ports.
  - The non-granted port sees gnt=0, wack=0, rvalid=0.
- Error: hb_error_i=1 in any state moves to ERROR.
  - err_o=1; wrq/rrq/gnt=0; no done pulse.
  - The block stays in ERROR until rst.
- Word counter is LEN_W+1 bits, so len = all-ones gives exactly 2^LEN_W words without wrap.

Decomposition:
- Package hbus_arb_pkg holds:
  - one-hot state encodings: INIT_WAIT, INIT_WR, INIT_REL, IDLE, ISSUE, XFER, RELEASE, ERROR;
  - CR0 address/value defaults;
  - the port index constants.
- One sub-module is natural: hbus_rr_pick, a combinational two-way round-robin picker (req[1:0], last_gnt -> grant one-hot).

Test Plan:
- Reset with INIT_EN=1, model busy=0 -> wrq=1, reg_space=1, adr=0x800, dat=0x8F1F; after ready, then busy low -> init_done=1, no port gnt beforehand.
- m0 write, len=3, adr=0x100, model ready on 4 cycles -> 4 wack pulses, words passed in order, wrq low after the 4th, one m0_done after busy=0.
- m1 read, len=1, model valid twice with 0xA5A5 then 0x5A5A -> m1_rvalid twice with those values, rrq drops after the 2nd, m1_done once.
- m0 and m1 request in the same cycle, both len=0 -> m0 served first, then m1. With both held high, grants alternate m0,m1,m0.
- hb_error_i pulsed mid m0 write burst -> err_o=1 sticky, wrq=0, no m0_done; after rst, normal init sequence resumes.
- rst asserted mid read burst -> rrq/gnt=0 immediately; init sequence reruns after rst deasserts.
